// File: rtl/alu_req_arbiter_if.sv
// Request/response and shared-ALU bundle for alu_req_arbiter.
// master is the arbiter side; slave is the requester/consumer/ALU environment.
interface alu_req_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [4*NREQ-1:0]  req_op;
    logic [DW*NREQ-1:0] req_a;
    logic [DW*NREQ-1:0] req_b;
    logic               resp_valid;
    logic               resp_ready;
    logic [IDW-1:0]     resp_id;
    logic [DW-1:0]      resp_data;
    logic               resp_zero;
    logic               resp_err;
    logic               busy;
    logic [3:0]         alu_control;
    logic [DW-1:0]      alu_a;
    logic [DW-1:0]      alu_b;
    logic [DW-1:0]      alu_out;
    logic               alu_zero;

    modport master (
        input  req_valid, req_op, req_a, req_b, resp_ready, alu_out, alu_zero,
        output req_ready, resp_valid, resp_id, resp_data, resp_zero, resp_err,
               busy, alu_control, alu_a, alu_b
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, resp_ready, alu_out, alu_zero,
        input  req_ready, resp_valid, resp_id, resp_data, resp_zero, resp_err,
               busy, alu_control, alu_a, alu_b
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Optional macro ALU_OPCODE_CHECK_EN: reject illegal opcodes with a 1-cycle error response.
module alu_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int ALU_LAT = 2,
    parameter int IDW     = 2
) (
    input logic               clk,
    input logic               rst_n,
    alu_req_arbiter_if.master bus
);
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      ctl_q, ctl_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            valid_q, valid_d, zero_q, zero_d, err_q, err_d;
    logic [NREQ-1:0] ready_c;
    logic            gnt_found;
    logic [IDW-1:0]  gnt_id;
    logic [3:0]      gnt_op;
    logic [DW-1:0]   gnt_a, gnt_b;

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

`ifdef ALU_OPCODE_CHECK_EN
    function automatic logic op_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd12, 4'd13};
    endfunction
`endif

    // First valid requester at or after rr_q, wrapping to 0
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && bus.req_valid[wrap_idx(rr_q, k)]) begin
                gnt_found = 1'b1;
                gnt_id    = wrap_idx(rr_q, k);
            end
        end
    end

    assign gnt_op = bus.req_op[4*gnt_id +: 4];
    assign gnt_a  = bus.req_a[DW*gnt_id +: DW];
    assign gnt_b  = bus.req_b[DW*gnt_id +: DW];

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        ctl_d   = ctl_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        data_d  = data_q;
        zero_d  = zero_q;
        valid_d = valid_q;
        err_d   = err_q;
        ready_c = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    ready_c[gnt_id] = 1'b1;
                    id_d = gnt_id;
                    rr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`ifdef ALU_OPCODE_CHECK_EN
                    if (!op_legal(gnt_op)) begin
                        data_d  = '0;
                        zero_d  = 1'b1;
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = RESP;
                    end else
`endif
                    begin
                        ctl_d   = gnt_op;
                        a_d     = gnt_a;
                        b_d     = gnt_b;
                        cnt_d   = CW'(ALU_LAT - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    data_d  = bus.alu_out;
                    zero_d  = bus.alu_zero;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            cnt_q   <= '0;
            ctl_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready   = ready_c;
    assign bus.resp_valid  = valid_q;
    assign bus.resp_id     = id_q;
    assign bus.resp_data   = data_q;
    assign bus.resp_zero   = zero_q;
`ifdef ALU_OPCODE_CHECK_EN
    assign bus.resp_err    = err_q;
`else
    // Without the check no error can be produced; err_q only ever holds 0
    assign bus.resp_err    = 1'b0 & err_q;
`endif
    assign bus.busy        = (state_q != IDLE);
    assign bus.alu_control = ctl_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
endmodule
